round_robin_arbiter_seq: RTL and testbench

//   Registered round-robin arbiter, parametrised in requester count. A rotating

---
 rtl/round_robin_arbiter_seq.sv | 130 +++++++++++++
 tb/tb_round_robin_arbiter_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/round_robin_arbiter_seq.sv
// round_robin_arbiter_seq: registered round-robin arbiter for `width` requesters.
// A rotating mask gives the most recently released owner the lowest priority.
// A grant is held until the owner asserts done or drops its request.
// Optional macro RR_TIMEOUT_EN: force-release a grant after max_hold cycles and
// pulse `timeout`. Without the macro, `timeout` is tied low and grants never expire.
module round_robin_arbiter_seq #(
    parameter int width    = 8,
    parameter int idx_w    = 3,
    parameter int max_hold = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] request,
    input  logic             done,
    output logic [width-1:0] grant,
    output logic             grant_valid,
    output logic [idx_w-1:0] grant_index,
    output logic             timeout
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    // Reject parameter sets the index/counter widths cannot represent.
    if (width < 2 || idx_w != $clog2(width) || max_hold < 1) begin : g_param_check
        $error("round_robin_arbiter_seq: illegal parameters");
    end

    logic [0:0]       state;
    logic [width-1:0] mask;

    logic             own_req;
    logic             to_hit;
    logic             release_grant;
    logic             load_grant;
    logic             pick_any;
    logic [width-1:0] above_g;
    logic [width-1:0] req_eff;
    logic [width-1:0] mask_eff;
    logic [width-1:0] masked;
    logic [width-1:0] cand;
    logic [width-1:0] pick_oh;
    logic [idx_w-1:0] pick_idx;

    // Release detection and arbitration. On a release, the owner is removed
    // from the request vector and the mask that will be stored is used right
    // away, so the next owner is granted on the same edge.
    always_comb begin
        own_req       = request[grant_index];
        release_grant = (state == GRANT) && (done || !own_req || to_hit);
        above_g       = '0;
        for (int i = 0; i < width; i++) begin
            above_g[i] = (i > int'(grant_index));
        end
        req_eff = request;
        if (release_grant) begin
            req_eff[grant_index] = 1'b0;
        end
        mask_eff = release_grant ? above_g : mask;
        masked   = req_eff & mask_eff;
        // An empty masked set falls back to the lowest unmasked requester.
        cand     = (|masked) ? masked : req_eff;
        pick_any = |req_eff;
        pick_idx = '0;
        for (int i = width - 1; i >= 0; i--) begin
            if (cand[i]) begin
                pick_idx = idx_w'(i);
            end
        end
        pick_oh           = '0;
        pick_oh[pick_idx] = 1'b1;
        load_grant        = ((state == IDLE) || release_grant) && pick_any;
    end

    // Grant/state/mask registers; the mask rotates only when a grant is released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            mask        <= '1;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_index <= '0;
        end else if (state == IDLE) begin
            if (pick_any) begin
                state       <= GRANT;
                grant       <= pick_oh;
                grant_valid <= 1'b1;
                grant_index <= pick_idx;
            end
        end else if (release_grant) begin
            mask <= above_g;
            if (pick_any) begin
                grant       <= pick_oh;
                grant_index <= pick_idx;
            end else begin
                state       <= IDLE;
                grant       <= '0;
                grant_valid <= 1'b0;
                grant_index <= '0;
            end
        end
    end

`ifdef RR_TIMEOUT_EN
    localparam int cnt_w = $clog2(max_hold + 1);

    logic [cnt_w-1:0] hold_cnt;

    assign to_hit = (state == GRANT) && (hold_cnt == cnt_w'(max_hold - 1));

    // Hold counter per grant; timeout flags a release caused only by the limit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= to_hit && !done && own_req;
            if (load_grant) begin
                hold_cnt <= '0;
            end else if (state == GRANT) begin
                hold_cnt <= hold_cnt + cnt_w'(1);
            end
        end
    end
`else
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_round_robin_arbiter_seq.sv
// Self-checking bench for round_robin_arbiter_seq (width=4, max_hold=4).
// Reference model: rotating-priority search starting just after the last
// released owner, evaluated once per clock edge.
module tb_round_robin_arbiter_seq;

    localparam int W  = 4;
    localparam int IW = 2;
    localparam int MH = 4;
`ifdef RR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  request;
    logic          done;
    logic [W-1:0]  grant;
    logic          grant_valid;
    logic [IW-1:0] grant_index;
    logic          timeout;

    int checks = 0;
    int errors = 0;

    // model state: current owner (-1 idle), last released owner (-1 = none)
    int m_owner = -1;
    int m_last  = -1;
    int m_cnt   = 0;
    bit m_to    = 1'b0;

    always #5 clk = ~clk;

    round_robin_arbiter_seq #(.width(W), .idx_w(IW), .max_hold(MH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .request     (request),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_index (grant_index),
        .timeout     (timeout)
    );

    function automatic int rr_pick(input logic [W-1:0] r, input int last);
        for (int k = 1; k <= W; k++) begin
            int i;
            i = (last + k) % W;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [W-1:0] r;
        bit           hit;
        bit           rel;
        r    = request;
        m_to = 1'b0;
        if (!rst_n) begin
            m_owner = -1;
            m_last  = -1;
            m_cnt   = 0;
        end else if (m_owner < 0) begin
            m_owner = rr_pick(r, m_last);
            m_cnt   = 0;
        end else begin
            hit = TO_EN && (m_cnt == MH - 1);
            rel = done || !r[m_owner] || hit;
            if (rel) begin
                m_to     = hit && !done && r[m_owner];
                m_last   = m_owner;
                r[m_owner] = 1'b0;
                m_owner  = rr_pick(r, m_last);
                m_cnt    = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: advance model with the applied inputs, then compare outputs
    task automatic step();
        logic [W-1:0]  eg;
        logic [IW-1:0] ei;
        @(posedge clk);
        model_step();
        #1;
        eg = '0;
        ei = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ei          = IW'(m_owner);
        end
        chk("model_grant", 32'(grant), 32'(eg));
        chk("model_valid", 32'(grant_valid), 32'(m_owner >= 0));
        chk("model_index", 32'(grant_index), 32'(ei));
        chk("model_timeout", 32'(timeout), 32'(m_to));
    endtask

    task automatic apply(input logic r_n, input logic [W-1:0] req, input logic dn);
        rst_n   = r_n;
        request = req;
        done    = dn;
        step();
    endtask

    initial begin
        int tcount;
        rst_n   = 1'b0;
        request = '0;
        done    = 1'b0;

        // 1: reset held with all requests high
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 4'b1111, 1'b0);
            chk("reset_grant", 32'(grant), 0);
            chk("reset_valid", 32'(grant_valid), 0);
            chk("reset_index", 32'(grant_index), 0);
        end

        // 2: rotation, back-to-back with done held
        apply(1'b1, 4'b1111, 1'b0);
        chk("rot0", 32'(grant), 32'h1);
        apply(1'b1, 4'b1111, 1'b1);
        chk("rot1", 32'(grant), 32'h2);
        chk("rot1_valid", 32'(grant_valid), 1);
        apply(1'b1, 4'b1111, 1'b1);
        chk("rot2", 32'(grant), 32'h4);
        apply(1'b1, 4'b1111, 1'b1);
        chk("rot3", 32'(grant), 32'h8);
        chk("rot3_index", 32'(grant_index), 3);
        apply(1'b1, 4'b1111, 1'b1);
        chk("rot_wrap", 32'(grant), 32'h1);

        // 3: skip and wrap via unmasked fallback
        apply(1'b0, 4'b0000, 1'b0);
        apply(1'b1, 4'b1010, 1'b0);
        chk("skip0", 32'(grant), 32'h2);
        apply(1'b1, 4'b1010, 1'b1);
        chk("skip1", 32'(grant), 32'h8);
        apply(1'b1, 4'b1010, 1'b1);
        chk("skip_wrap", 32'(grant), 32'h2);

        // 4: new request does not pre-empt; owner drop releases
        apply(1'b0, 4'b0000, 1'b0);
        apply(1'b1, 4'b0100, 1'b0);
        chk("drop_own", 32'(grant), 32'h4);
        apply(1'b1, 4'b0101, 1'b0);
        chk("no_preempt", 32'(grant), 32'h4);
        apply(1'b1, 4'b0001, 1'b0);
        chk("drop_next", 32'(grant), 32'h1);
        chk("drop_index", 32'(grant_index), 0);

        // 5: timeout (or indefinite hold without the option)
        apply(1'b0, 4'b0000, 1'b0);
        tcount = 0;
        if (TO_EN) begin
            for (int i = 0; i < 4; i++) begin
                apply(1'b1, 4'b0011, 1'b0);
                chk("to_hold", 32'(grant), 32'h1);
                tcount += int'(timeout);
            end
            apply(1'b1, 4'b0011, 1'b0);
            chk("to_next", 32'(grant), 32'h2);
            tcount += int'(timeout);
            apply(1'b1, 4'b0011, 1'b0);
            tcount += int'(timeout);
            chk("to_pulses", 32'(tcount), 1);
        end else begin
            for (int i = 0; i < 110; i++) begin
                apply(1'b1, 4'b0011, 1'b0);
                tcount += int'(timeout);
            end
            chk("hold_forever", 32'(grant), 32'h1);
            chk("no_timeout", 32'(tcount), 0);
        end

        // 6: reset mid-grant restores requester-0 priority
        apply(1'b0, 4'b0000, 1'b0);
        apply(1'b1, 4'b1000, 1'b0);
        chk("mid_own", 32'(grant), 32'h8);
        apply(1'b0, 4'b1111, 1'b0);
        chk("mid_reset", 32'(grant), 0);
        apply(1'b1, 4'b1111, 1'b0);
        chk("mid_after", 32'(grant), 32'h1);

        // randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            logic [W-1:0] nr;
            nr = request;
            if ($urandom_range(0, 3) == 0) nr = W'($urandom);
            apply(($urandom_range(0, 49) != 0), nr, ($urandom_range(0, 4) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
